// File: rtl/alu_ctrl_pkg.sv
// Shared decode constants, FSM encoding and the ALU-control decode helper
// for the ALU control unit with its iterative multiply/divide unit.
package alu_ctrl_pkg;

    localparam logic [3:0] SEL_AND  = 4'b0000;
    localparam logic [3:0] SEL_OR   = 4'b0001;
    localparam logic [3:0] SEL_ADD  = 4'b0010;
    localparam logic [3:0] SEL_SUB  = 4'b0110;
    localparam logic [3:0] SEL_SLT  = 4'b0111;
    localparam logic [3:0] SEL_SLTU = 4'b0101;
    localparam logic [3:0] SEL_XOR  = 4'b0011;
    localparam logic [3:0] SEL_NOR  = 4'b1100;
    localparam logic [3:0] SEL_SLL  = 4'b1000;
    localparam logic [3:0] SEL_SRL  = 4'b1001;
    localparam logic [3:0] SEL_SRA  = 4'b1010;

    localparam logic [1:0] HILO_ALU = 2'b00;
    localparam logic [1:0] HILO_HI  = 2'b01;
    localparam logic [1:0] HILO_LO  = 2'b10;

    localparam logic [1:0] AOP_ADD   = 2'b00;
    localparam logic [1:0] AOP_SUB   = 2'b01;
    localparam logic [1:0] AOP_RTYPE = 2'b10;
    localparam logic [1:0] AOP_ORI   = 2'b11;

    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_MUL   = 2'b01;
    localparam logic [1:0] ST_DIV   = 2'b10;
    localparam logic [1:0] ST_FIXUP = 2'b11;

    typedef struct packed {
        logic [3:0] sel;
        logic [1:0] hilo;
    } dec_t;

    // mult/multu/div/divu all share the 0110xx funct prefix
    function automatic logic is_md_func(input logic [5:0] f);
        return f[5:2] == 4'b0110;
    endfunction

    function automatic dec_t decode(input logic [1:0] alu_op, input logic [5:0] f);
        dec_t d;
        d.sel  = SEL_ADD;
        d.hilo = HILO_ALU;
        unique case (alu_op)
            AOP_ADD: d.sel = SEL_ADD;
            AOP_SUB: d.sel = SEL_SUB;
            AOP_ORI: d.sel = SEL_OR;
            default: begin
                unique case (f)
                    F_ADD, F_ADDU: d.sel = SEL_ADD;
                    F_SUB, F_SUBU: d.sel = SEL_SUB;
                    F_AND:   d.sel  = SEL_AND;
                    F_OR:    d.sel  = SEL_OR;
                    F_XOR:   d.sel  = SEL_XOR;
                    F_NOR:   d.sel  = SEL_NOR;
                    F_SLT:   d.sel  = SEL_SLT;
                    F_SLTU:  d.sel  = SEL_SLTU;
                    F_SLL:   d.sel  = SEL_SLL;
                    F_SRL:   d.sel  = SEL_SRL;
                    F_SRA:   d.sel  = SEL_SRA;
                    F_MFHI:  d.hilo = HILO_HI;
                    F_MFLO:  d.hilo = HILO_LO;
                    default: d.sel  = SEL_ADD;
                endcase
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/md_iter.sv
// Iterative unsigned multiply/divide datapath: one shift-add or restoring
// subtract step per cycle on magnitudes held in the hi/lo working registers.
module md_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q,  b_d;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // Multiply: lo holds the multiplier, product shifts right through hi:lo.
    // Divide: lo holds the dividend, quotient bits shift in from the right.
    always_comb begin
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        shifted = {hi_q, lo_q[WIDTH-1]};
        diff    = shifted - {1'b0, b_q};
        hi_d    = hi_q;
        lo_d    = lo_q;
        b_d     = b_q;
        if (load_i) begin
            hi_d = '0;
            lo_d = a_i;
            b_d  = b_i;
        end else if (step_i) begin
            if (is_div_i) begin
                if (shifted >= {1'b0, b_q}) begin
                    hi_d = diff[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = shifted[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                hi_d = sum[WIDTH:1];
                lo_d = {sum[0], lo_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
            b_q  <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            b_q  <= b_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/alu_control_mdu.sv
// ALU control decode plus multi-cycle multiply/divide sequencer owning the
// architectural HI/LO registers and the pipeline stall for HI/LO hazards.
module alu_control_mdu
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SELW  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       func,
    input  logic             valid,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [SELW-1:0]  alu_sel,
    output logic [1:0]       hilo_sel,
    output logic             stall,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNTW = $clog2(WIDTH);
    localparam logic [CNTW-1:0] LAST_STEP = CNTW'(WIDTH - 1);

    logic [1:0]         state_q, state_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic               op_div_q, op_div_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               div_zero_q, div_zero_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    dec_t               dec;
    logic               md_req, hilo_req, accept;
    logic               op_signed, rs_neg, rt_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   it_hi, it_lo;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign dec      = decode(alu_op, func);
    assign alu_sel  = SELW'(dec.sel);
    assign hilo_sel = dec.hilo;

    assign md_req   = valid && (alu_op == AOP_RTYPE) && is_md_func(func);
    assign hilo_req = valid && (alu_op == AOP_RTYPE) && (func == F_MFHI || func == F_MFLO);
    assign accept   = md_req && (state_q == ST_IDLE);
    assign stall    = (md_req || hilo_req) && (state_q != ST_IDLE);
    assign md_busy  = state_q != ST_IDLE;
    assign md_done  = done_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

    // funct bit 0 distinguishes unsigned variants, bit 1 divide from multiply
    assign op_signed = ~func[0];
    assign rs_neg    = op_signed & rs_val[WIDTH-1];
    assign rt_neg    = op_signed & rt_val[WIDTH-1];
    assign a_mag     = rs_neg ? -rs_val : rs_val;
    assign b_mag     = rt_neg ? -rt_val : rt_val;

    md_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (accept),
        .step_i   ((state_q == ST_MUL) || (state_q == ST_DIV)),
        .is_div_i (state_q == ST_DIV),
        .a_i      (a_mag),
        .b_i      (b_mag),
        .hi_o     (it_hi),
        .lo_o     (it_lo)
    );

    // Zero divisor leaves remainder = |dividend|, so sign restore yields the dividend
    assign prod     = {it_hi, it_lo};
    assign prod_fix = neg_q ? -prod : prod;
    assign quo_fix  = div_zero_q ? '1 : (neg_q ? -it_lo : it_lo);
    assign rem_fix  = rem_neg_q ? -it_hi : it_hi;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_div_d   = op_div_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = func[1] ? ST_DIV : ST_MUL;
                    cnt_d      = '0;
                    op_div_d   = func[1];
                    neg_d      = rs_neg ^ rt_neg;
                    rem_neg_d  = rs_neg;
                    div_zero_d = (rt_val == '0);
                end
            end
            ST_MUL, ST_DIV: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = ST_FIXUP;
                end
            end
            ST_FIXUP: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                if (op_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            op_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_div_q   <= op_div_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            div_zero_q <= div_zero_d;
            done_q     <= done_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

endmodule

// File: tb/tb_alu_control_mdu.sv
// Scoreboard bench for alu_control_mdu: directed decode and multiply/divide
// vectors with hand-computed HI/LO results and completion cycles.
module tb_alu_control_mdu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  alu_op;
    logic [5:0]  func;
    logic        valid;
    logic [31:0] rs_val, rt_val;
    logic [3:0]  alu_sel;
    logic [1:0]  hilo_sel;
    logic        stall, md_busy, md_done;
    logic [31:0] hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [1:0] op;
        logic [5:0] f;
        logic [3:0] sel;
        logic [1:0] hs;
    } dvec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    alu_control_mdu #(.WIDTH(32), .SELW(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .alu_op   (alu_op),
        .func     (func),
        .valid    (valid),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .alu_sel  (alu_sel),
        .hilo_sel (hilo_sel),
        .stall    (stall),
        .md_busy  (md_busy),
        .md_done  (md_done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
        end
    endtask

    // Monitor: every md_done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && md_done) begin
            if (sb.size() == 0) begin
                chk("done_unexpected", 64'(md_done), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_hi", 64'(hi), 64'(e.hi));
                chk("done_lo", 64'(lo), 64'(e.lo));
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Call at negedge+1 with the unit idle; returns just after the accepting edge
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el);
        valid  = 1'b1;
        alu_op = 2'b10;
        func   = f;
        rs_val = a;
        rt_val = b;
        @(posedge clk);
        #1;
        sb.push_back('{eh, el, cyc + 33});
        chk("accept_busy", 64'(md_busy), 64'(1));
        valid  = 1'b0;
        rs_val = $urandom;
        rt_val = $urandom;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0 && !md_busy) return;
        end
        chk("drain_timeout", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        dvec_t dv[8];
        int    gaps;
        int    nst;

        rst_n  = 1'b0;
        valid  = 1'b1;
        alu_op = 2'b00;
        func   = 6'b0;
        rs_val = '0;
        rt_val = '0;
        #1;
        chk("rst_hi", 64'(hi), 64'(0));
        chk("rst_lo", 64'(lo), 64'(0));
        chk("rst_busy", 64'(md_busy), 64'(0));
        chk("rst_done", 64'(md_done), 64'(0));

        dv[0] = '{2'b00, 6'b000000, 4'b0010, 2'b00};
        dv[1] = '{2'b01, 6'b000000, 4'b0110, 2'b00};
        dv[2] = '{2'b10, 6'b100010, 4'b0110, 2'b00};
        dv[3] = '{2'b10, 6'b100111, 4'b1100, 2'b00};
        dv[4] = '{2'b10, 6'b010000, 4'b0010, 2'b01};
        dv[5] = '{2'b11, 6'b100100, 4'b0001, 2'b00};
        dv[6] = '{2'b10, 6'b101011, 4'b0101, 2'b00};
        dv[7] = '{2'b10, 6'b000011, 4'b1010, 2'b00};
        for (int i = 0; i < 8; i++) begin
            alu_op = dv[i].op;
            func   = dv[i].f;
            #1;
            chk($sformatf("dec%0d_sel", i), 64'(alu_sel), 64'(dv[i].sel));
            chk($sformatf("dec%0d_hilo", i), 64'(hilo_sel), 64'(dv[i].hs));
            chk($sformatf("dec%0d_stall", i), 64'(stall), 64'(0));
        end
        valid = 1'b0;

        // Release and accept on the very first edge; trace md_busy over the window
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        issue(6'b011000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
        gaps = 0;
        for (int i = 0; i < 33; i++) begin
            @(negedge clk);
            if (!md_busy || md_done) gaps++;
        end
        @(negedge clk);
        #1;
        chk("mult_busy_window_gaps", 64'(gaps), 64'(0));
        chk("mult_busy_after", 64'(md_busy), 64'(0));
        chk("mult_done_pulse", 64'(md_done), 64'(1));
        wait_idle();

        // mflo right behind a mult stalls until the result lands
        issue(6'b011000, 32'd6, 32'd7, 32'd0, 32'd42);
        valid = 1'b1; alu_op = 2'b10; func = 6'b010010;
        nst = 0; gaps = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (md_done) break;
            if (stall) nst++; else gaps++;
        end
        chk("mflo_done_seen", 64'(md_done), 64'(1));
        chk("mflo_stall_cycles", 64'(nst), 64'(33));
        chk("mflo_stall_gaps", 64'(gaps), 64'(0));
        chk("mflo_stall_release", 64'(stall), 64'(0));
        chk("mflo_hilo_sel", 64'(hilo_sel), 64'(2'b10));
        chk("mflo_lo", 64'(lo), 64'(42));
        valid = 1'b0;
        wait_idle();

        // divu presented while busy is held off, then accepted after completion
        issue(6'b011000, 32'd2, 32'd3, 32'd0, 32'd6);
        valid = 1'b1; alu_op = 2'b10; func = 6'b011011; rs_val = 32'd100; rt_val = 32'd7;
        nst = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (md_done) break;
            if (stall) nst++;
        end
        chk("busy_md_stall_cycles", 64'(nst), 64'(33));
        chk("busy_md_stall_release", 64'(stall), 64'(0));
        sb.push_back('{32'd2, 32'd14, cyc + 34});
        @(posedge clk);
        #1;
        chk("busy_md_accept", 64'(md_busy), 64'(1));
        valid = 1'b0; rs_val = $urandom; rt_val = $urandom;
        wait_idle();

        issue(6'b011010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        wait_idle();
        issue(6'b011010, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
        wait_idle();
        issue(6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
        wait_idle();
        issue(6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        wait_idle();

        // Reset mid-multiply: everything clears at once and no md_done follows
        issue(6'b011000, 32'h12345678, 32'd9, 32'd0, 32'hA3D70A38);
        repeat (10) @(posedge clk);
        #1;
        chk("abort_busy_before", 64'(md_busy), 64'(1));
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("abort_hi", 64'(hi), 64'(0));
        chk("abort_lo", 64'(lo), 64'(0));
        chk("abort_busy", 64'(md_busy), 64'(0));
        chk("abort_done", 64'(md_done), 64'(0));
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        issue(6'b011001, 32'd3, 32'd4, 32'd0, 32'd12);
        wait_idle();
        repeat (40) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
